// File: rtl/cache_mem_arbiter_if.sv
// rtl/cache_mem_arbiter_if.sv - cache refill/writeback requests and memory beat bus
// The arbiter uses the slave modport; caches and memory use the master modport.
interface cache_mem_arbiter_if #(
  parameter int WORD             = 32,
  parameter int CACHE_LINE_WIDTH = 128
);
  logic                        i_req_valid;
  logic [WORD-1:0]             i_req_addr;
  logic                        i_resp_ready;
  logic [CACHE_LINE_WIDTH-1:0] i_resp_line;
  logic                        d_rd_valid;
  logic [WORD-1:0]             d_rd_addr;
  logic                        d_rd_ready;
  logic [CACHE_LINE_WIDTH-1:0] d_rd_line;
  logic                        d_wr_valid;
  logic [WORD-1:0]             d_wr_addr;
  logic [CACHE_LINE_WIDTH-1:0] d_wr_line;
  logic                        d_wr_done;
  logic                        mem_valid;
  logic                        mem_we;
  logic [WORD-1:0]             mem_addr;
  logic [WORD-1:0]             mem_wdata;
  logic                        mem_ready;
  logic [WORD-1:0]             mem_rdata;

  modport slave (
    input  i_req_valid, i_req_addr, d_rd_valid, d_rd_addr,
    input  d_wr_valid, d_wr_addr, d_wr_line, mem_ready, mem_rdata,
    output i_resp_ready, i_resp_line, d_rd_ready, d_rd_line, d_wr_done,
    output mem_valid, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req_valid, i_req_addr, d_rd_valid, d_rd_addr,
    output d_wr_valid, d_wr_addr, d_wr_line, mem_ready, mem_rdata,
    input  i_resp_ready, i_resp_line, d_rd_ready, d_rd_line, d_wr_done,
    input  mem_valid, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shares one word-wide memory port between ICache and DCache
// Each grant moves one 4-word line; writebacks win, refill ties alternate.
module cache_mem_arbiter #(
  parameter int WORD             = 32,
  parameter int CACHE_LINE_WIDTH = 128
) (
  input logic                clk,
  input logic                rst,
  cache_mem_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, D_WR, D_RD, I_RD, RESP} state_e;

  state_e                      state_q;
  logic [1:0]                  beat_q;
  logic [WORD-1:0]             base_q;
  logic [WORD-1:0]             base_d;
  logic [WORD-1:0]             addr_sel;
  logic                        last_i_q;
  logic [3*WORD-1:0]           buf_q;
  logic [CACHE_LINE_WIDTH-1:0] i_line_q;
  logic [CACHE_LINE_WIDTH-1:0] d_line_q;
  logic                        i_rdy_q;
  logic                        d_rdy_q;
  logic                        d_done_q;
  logic                        xfer;
  logic                        grant_wr;
  logic                        grant_i;
  logic                        grant_d;

  // last_i_q low means the DCache read was served last, so the ICache wins a tie.
  always_comb begin
    grant_wr = bus.d_wr_valid;
    grant_i  = !bus.d_wr_valid && bus.i_req_valid && (!bus.d_rd_valid || !last_i_q);
    grant_d  = !bus.d_wr_valid && bus.d_rd_valid && !grant_i;
    if (grant_wr)     addr_sel = bus.d_wr_addr;
    else if (grant_i) addr_sel = bus.i_req_addr;
    else              addr_sel = bus.d_rd_addr;
    base_d = addr_sel & ~WORD'(15);
    xfer   = (state_q == D_WR) || (state_q == D_RD) || (state_q == I_RD);
  end

  assign bus.mem_valid    = xfer;
  assign bus.mem_we       = (state_q == D_WR);
  assign bus.mem_addr     = xfer ? base_q + WORD'({beat_q, 2'b00}) : '0;
  assign bus.mem_wdata    = (state_q == D_WR) ? bus.d_wr_line[int'(beat_q)*WORD +: WORD] : '0;
  assign bus.i_resp_ready = i_rdy_q;
  assign bus.i_resp_line  = i_line_q;
  assign bus.d_rd_ready   = d_rdy_q;
  assign bus.d_rd_line    = d_line_q;
  assign bus.d_wr_done    = d_done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      base_q   <= '0;
      last_i_q <= 1'b0;
      buf_q    <= '0;
      i_line_q <= '0;
      d_line_q <= '0;
      i_rdy_q  <= 1'b0;
      d_rdy_q  <= 1'b0;
      d_done_q <= 1'b0;
    end else begin
      i_rdy_q  <= 1'b0;
      d_rdy_q  <= 1'b0;
      d_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          beat_q <= '0;
          if (grant_wr || grant_i || grant_d) base_q <= base_d;
          if (grant_wr) begin
            state_q <= D_WR;
          end else if (grant_i) begin
            state_q  <= I_RD;
            last_i_q <= 1'b1;
          end else if (grant_d) begin
            state_q  <= D_RD;
            last_i_q <= 1'b0;
          end
        end
        D_WR, D_RD, I_RD: begin
          if (bus.mem_ready) begin
            beat_q <= beat_q + 2'd1;
            if (state_q != D_WR) begin
              case (beat_q)
                2'd0:    buf_q[WORD-1:0]        <= bus.mem_rdata;
                2'd1:    buf_q[2*WORD-1:WORD]   <= bus.mem_rdata;
                2'd2:    buf_q[3*WORD-1:2*WORD] <= bus.mem_rdata;
                default: ;
              endcase
            end
            // The final beat goes straight into the visible line so it is ready in RESP.
            if (beat_q == 2'd3) begin
              state_q  <= RESP;
              d_done_q <= (state_q == D_WR);
              d_rdy_q  <= (state_q == D_RD);
              i_rdy_q  <= (state_q == I_RD);
              if (state_q == D_RD) d_line_q <= {bus.mem_rdata, buf_q};
              if (state_q == I_RD) i_line_q <= {bus.mem_rdata, buf_q};
            end
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 SHALL have parameter WORD, default 32, meaning data/address width.
REQ-002 SHALL have parameter CACHE_LINE_WIDTH, default 128, meaning cache line width (4 x WORD).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1, meaning reset, asynchronous, active-low.
REQ-005 SHALL have port i_req_valid, input, 1, meaning ICache line-refill request, held until i_resp_ready.
REQ-006 SHALL have port i_req_addr, input, WORD, meaning ICache refill address.
REQ-007 SHALL have port i_resp_ready, output, 1, meaning one-cycle pulse: ICache refill line valid.
REQ-008 SHALL have port i_resp_line, output, CACHE_LINE_WIDTH, meaning ICache refill data.
REQ-009 SHALL have port d_rd_valid, input, 1, meaning DCache refill request.
REQ-010 SHALL have port d_rd_addr, input, WORD, meaning DCache refill address.
REQ-011 SHALL have port d_rd_ready, output, 1, meaning one-cycle pulse: DCache refill line valid.
REQ-012 SHALL have port d_rd_line, output, CACHE_LINE_WIDTH, meaning DCache refill data.
REQ-013 SHALL have port d_wr_valid, input, 1, meaning DCache dirty-line writeback request.
REQ-014 SHALL have port d_wr_addr, input, WORD, meaning writeback address.
REQ-015 SHALL have port d_wr_line, input, CACHE_LINE_WIDTH, meaning writeback data, stable while d_wr_valid.
REQ-016 SHALL have port d_wr_done, output, 1, meaning one-cycle pulse: writeback complete.
REQ-017 SHALL have port mem_valid, output, 1, meaning memory beat request.
REQ-018 SHALL have port mem_we, output, 1, meaning beat is a write.
REQ-019 SHALL have port mem_addr, output, WORD, meaning beat word address.
REQ-020 SHALL have port mem_wdata, output, WORD, meaning write beat data.
REQ-021 SHALL have port mem_ready, input, 1, meaning beat accepted; read data valid this cycle.
REQ-022 SHALL have port mem_rdata, input, WORD, meaning read beat data.

Function
REQ-023 SHALL implement states IDLE, D_WR, D_RD, I_RD, RESP.
REQ-024 In IDLE SHALL grant: d_wr_valid first; else if exactly one of d_rd_valid/i_req_valid, that one; else if both, the one not granted last (last_grant flag).
REQ-025 On grant SHALL latch line base = addr with bits[3:0] zeroed and clear 2-bit beat counter; next cycle enters D_WR/D_RD/I_RD.
REQ-026 In transfer states SHALL drive mem_valid=1, mem_addr=base+4*beat, mem_we=1 only in D_WR, mem_wdata=d_wr_line[32*beat+31:32*beat].
REQ-027 A beat SHALL complete only when mem_valid&&mem_ready; while mem_ready=0 all mem outputs hold.
REQ-028 On each read beat completion SHALL store mem_rdata into line buffer slice [32*beat+31:32*beat].
REQ-029 Beat counter SHALL increment per completed beat; completion of beat 3 moves to RESP, counter wraps to 0.
REQ-030 In RESP (exactly one cycle) SHALL pulse the owner's ready/done and return to IDLE; mem_valid=0.
REQ-031 i_resp_line/d_rd_line SHALL update only at RESP of the respective read and hold until the next one.
REQ-032 Requesters SHALL drop valid the cycle after ready/done; arbiter never samples requests in RESP.
REQ-033 Request deasserted mid-transfer: transfer SHALL still finish all 4 beats and pulse response.
REQ-034 last_grant SHALL update only on D_RD or I_RD grants; D_WR grants do not change it.
REQ-035 Latency from grant to response pulse with mem_ready tied 1: 1 (grant) + 4 beats + 1 (RESP) = 6 cycles.

Reset
REQ-036 On rst=0 SHALL asynchronously force state IDLE, beat=0, last_grant=D (I wins first tie), all outputs and line buffers 0.
REQ-037 Reset mid-transfer SHALL abort without response pulse; after release, pending requests re-arbitrate from IDLE.

Verification
REQ-038 I-only: i_req_addr=0x1C00_0014, mem_ready=1, rdata=beat index+0xA0 -> mem_addr 0x1C00_0010..1C, i_resp_line=0x000000A3_000000A2_000000A1_000000A0, pulse 6 cycles after request.
REQ-039 Simultaneous d_wr, d_rd, i_req -> order D_WR, then I_RD, then D_RD; each response one cycle wide.
REQ-040 Writeback d_wr_line=0x44444444_33333333_22222222_11111111 -> mem_wdata 0x11111111..0x44444444 with mem_we=1; d_wr_done pulse.
REQ-041 mem_ready low 3 cycles on beat 2 -> mem_addr/mem_wdata held, no beat skipped, latency +3.
REQ-042 rst=0 asserted during beat 1 of I_RD -> outputs 0 immediately, no i_resp_ready; request held retries to completion after release.
REQ-043 Back-to-back d_rd and i_req held continuously -> grants alternate I, D, I, D.
